// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring) unit
// feeding the MIPS HI/LO registers; 33 edges from start to done for either op.
//
// state  | meaning
// IDLE   | waiting for mult_start/div_start
// MULT   | Booth iterations, counter counts 32 down to 1
// DIV    | restoring-division iterations on magnitudes
// FIX    | commit product, or sign-corrected quotient/remainder
// DONE   | one-cycle done strobe (div_zero too on a zero divisor)
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        done,
    output logic        busy,
    output logic        div_zero
);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [32:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic        r_qm1;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dz;
    logic [31:0] r_hi_out;
    logic [31:0] r_lo_out;

    logic        w_b_zero;
    logic        w_dz_start;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_opnd_sx;
    logic [32:0] w_booth_sum;
    logic [32:0] w_shift;
    logic [33:0] w_trial;
    logic        w_trial_ok;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_b_zero   = (op_b == 32'd0);
    assign w_dz_start = !mult_start && div_start && w_b_zero;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_mag_a    = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign w_mag_b    = op_b[31] ? (~op_b + 32'd1) : op_b;

    assign w_opnd_sx  = {r_opnd[31], r_opnd};

    always_comb begin
        w_booth_sum = r_acc_hi;
        case ({r_acc_lo[0], r_qm1})
            2'b01:   w_booth_sum = r_acc_hi + w_opnd_sx;
            2'b10:   w_booth_sum = r_acc_hi - w_opnd_sx;
            default: w_booth_sum = r_acc_hi;
        endcase
    end

    // The partial remainder stays below the divisor, so 33 bits hold the shift
    assign w_shift    = {r_acc_hi[31:0], r_acc_lo[31]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, r_opnd};
    assign w_trial_ok = ~w_trial[33];

    assign w_quo_fix  = r_sign_q ? (~r_acc_lo + 32'd1) : r_acc_lo;
    assign w_rem_fix  = r_sign_r ? (~r_acc_hi[31:0] + 32'd1) : r_acc_hi[31:0];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mult_start)                 w_next = S_MULT;
                else if (div_start && !w_b_zero) w_next = S_DIV;
                else if (div_start)             w_next = S_DONE;
            end
            S_MULT:  if (r_cnt == 6'd1) w_next = S_FIX;
            S_DIV:   if (r_cnt == 6'd1) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_MULT) || (r_state == S_DIV) || (r_state == S_FIX);
        done     = (r_state == S_DONE);
        div_zero = (r_state == S_DONE) && r_dz;
    end

    assign hi_out = r_hi_out;
    assign lo_out = r_lo_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 6'd0;
            r_acc_hi <= 33'd0;
            r_acc_lo <= 32'd0;
            r_qm1    <= 1'b0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_hi_out <= 32'd0;
            r_lo_out <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dz <= w_dz_start;
                    if (mult_start) begin
                        r_acc_hi <= 33'd0;
                        r_acc_lo <= op_b;
                        r_qm1    <= 1'b0;
                        r_opnd   <= op_a;
                        r_cnt    <= 6'd32;
                        r_is_div <= 1'b0;
                    end else if (div_start && !w_b_zero) begin
                        r_acc_hi <= 33'd0;
                        r_acc_lo <= w_mag_a;
                        r_opnd   <= w_mag_b;
                        r_sign_q <= op_a[31] ^ op_b[31];
                        r_sign_r <= op_a[31];
                        r_cnt    <= 6'd32;
                        r_is_div <= 1'b1;
                    end
                end
                S_MULT: begin
                    r_acc_hi <= {w_booth_sum[32], w_booth_sum[32:1]};
                    r_acc_lo <= {w_booth_sum[0], r_acc_lo[31:1]};
                    r_qm1    <= r_acc_lo[0];
                    r_cnt    <= r_cnt - 6'd1;
                end
                S_DIV: begin
                    r_acc_hi <= w_trial_ok ? w_trial[32:0] : w_shift;
                    r_acc_lo <= {r_acc_lo[30:0], w_trial_ok};
                    r_cnt    <= r_cnt - 6'd1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi_out <= w_rem_fix;
                        r_lo_out <= w_quo_fix;
                    end else begin
                        r_hi_out <= r_acc_hi[31:0];
                        r_lo_out <= r_acc_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products/quotients, latency,
// busy window, divide-by-zero, start priority/ignoring and mid-operation reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        busy;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .done       (done),
        .busy       (busy),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one op, then count negedges until done (k=1 is the cycle after T0).
    task automatic run_op(input logic do_mult, input logic do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz);
        lat  = -1;
        bcnt = 0;
        hi   = 32'hDEADBEEF;
        lo   = 32'hDEADBEEF;
        dz   = 1'b0;
        @(negedge clk);
        mult_start = do_mult;
        div_start  = do_div;
        op_a       = a;
        op_b       = b;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                hi  = hi_out;
                lo  = lo_out;
                dz  = div_zero;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        string       tag;
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7] = '{
        '{"mul_6x7",      1'b1, 32'd6,        32'd7,        32'h00000000, 32'h0000002A},
        '{"mul_m3x5",     1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1},
        '{"mul_min_min",  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{"mul_max_max",  1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001},
        '{"div_m7_2",     1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
        '{"div_min_m1",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{"div_7_m2",     1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}
    };

    initial begin
        int          lat, bcnt, ndone;
        logic [31:0] hi, lo;
        logic        dz;

        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hi",   hi_out, 32'd0);
        check("rst_lo",   lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz",   {31'd0, div_zero}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b, lat, bcnt, hi, lo, dz);
            check({vecs[i].tag, "_hi"},   hi, vecs[i].hi);
            check({vecs[i].tag, "_lo"},   lo, vecs[i].lo);
            check({vecs[i].tag, "_lat"},  lat, 32'd34);
            check({vecs[i].tag, "_busy"}, bcnt, 32'd33);
            check({vecs[i].tag, "_dz"},   {31'd0, dz}, 32'd0);
        end

        // Divide by zero right after 7/-2: previous result retained, no busy
        run_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bcnt, hi, lo, dz);
        check("dz_lat",  lat, 32'd1);
        check("dz_busy", bcnt, 32'd0);
        check("dz_flag", {31'd0, dz}, 32'd1);
        check("dz_hi",   hi, 32'h00000001);
        check("dz_lo",   lo, 32'hFFFFFFFD);

        // Both starts together: 100*7 = 700, divide would give 14
        run_op(1'b1, 1'b1, 32'd100, 32'd7, lat, bcnt, hi, lo, dz);
        check("both_lo", lo, 32'd700);
        check("both_hi", hi, 32'd0);
        check("both_dz", {31'd0, dz}, 32'd0);

        // div_start (zero divisor) pulsed mid-multiply must be ignored
        @(negedge clk);
        mult_start = 1'b1;
        op_a = 32'd3;
        op_b = 32'd4;
        @(negedge clk);
        mult_start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 10) begin
                div_start = 1'b1;
                op_b = 32'd0;
            end else begin
                div_start = 1'b0;
            end
            if (done) begin
                ndone++;
                check("ign_lat", k, 32'd34);
                check("ign_lo", lo_out, 32'd12);
            end
            @(negedge clk);
        end
        check("ign_ndone", ndone, 32'd1);

        // Reset after the 15th divide iteration
        @(negedge clk);
        div_start = 1'b1;
        op_a = 32'd100;
        op_b = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", hi_out, 32'd0);
        check("mid_rst_lo", lo_out, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("mid_rst_ndone", ndone, 32'd0);

        // Unit must be back in IDLE and fully functional
        run_op(1'b1, 1'b0, 32'd5, 32'hFFFFFFFB, lat, bcnt, hi, lo, dz);
        check("post_rst_lo",  lo, 32'hFFFFFFE7);
        check("post_rst_hi",  hi, 32'hFFFFFFFF);
        check("post_rst_lat", lat, 32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
